// File: rtl/mont_arbiter_if.sv
// mont_arbiter_if: requester-side and engine-side signals of the montgomery arbiter
interface mont_arbiter_if #(
  parameter int bitwidth = 256,
  parameter int NREQ = 2
);
  logic [NREQ-1:0] req;
  logic [NREQ*bitwidth-1:0] a;
  logic [NREQ*bitwidth-1:0] b;
  logic [NREQ-1:0] grant;
  logic busy;
  logic [NREQ-1:0] done;
  logic err;
  logic [bitwidth-1:0] result;
  logic mont_start;
  logic [bitwidth-1:0] mont_a;
  logic [bitwidth-1:0] mont_b;
  logic mont_finished;
  logic [bitwidth-1:0] mont_result;
  modport slave (
    input req, a, b, mont_finished, mont_result,
    output grant, busy, done, err, result, mont_start, mont_a, mont_b
  );
  modport master (
    output req, a, b, mont_finished, mont_result,
    input grant, busy, done, err, result, mont_start, mont_a, mont_b
  );
endinterface

// File: rtl/mont_arbiter.sv
// mont_arbiter: round-robin sharing of one montgomery engine among NREQ requesters
module mont_arbiter #(
  parameter int bitwidth = 256,
  parameter int NREQ = 2,
  parameter int TIMEOUT = 1024
) (
  input logic i_clk,
  input logic i_rst_n,
  mont_arbiter_if.slave bus
);
  localparam int IW = $clog2(NREQ);
  localparam int WW = TIMEOUT > 2 ? $clog2(TIMEOUT) : 1;
  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;
  state_t state;
  logic [IW-1:0] rr;
  logic [IW-1:0] gidx;
  logic [IW-1:0] sel;
  logic found;
  logic [WW-1:0] wdog;
  // first requester at or after the rr pointer, wrapping; lowest offset wins
  always_comb begin
    found = 1'b0;
    sel = '0;
    for (int i = NREQ - 1; i >= 0; i--)
      if (bus.req[(int'(rr) + i) % NREQ]) begin
        found = 1'b1;
        sel = IW'((int'(rr) + i) % NREQ);
      end
  end
  // arbitration fsm; every output is a register updated on the transition into its state
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state <= S_IDLE;
      rr <= '0;
      gidx <= '0;
      wdog <= '0;
      bus.grant <= '0;
      bus.busy <= 1'b0;
      bus.done <= '0;
      bus.err <= 1'b0;
      bus.result <= '0;
      bus.mont_start <= 1'b0;
      bus.mont_a <= '0;
      bus.mont_b <= '0;
    end else begin
      case (state)
        S_IDLE: if (found) begin
          gidx <= sel;
          bus.grant <= NREQ'(1) << sel;
          bus.mont_a <= bus.a[int'(sel)*bitwidth +: bitwidth];
          bus.mont_b <= bus.b[int'(sel)*bitwidth +: bitwidth];
          bus.mont_start <= 1'b1;
          bus.busy <= 1'b1;
          state <= S_ISSUE;
        end
        S_ISSUE: begin
          bus.mont_start <= 1'b0;
          wdog <= '0;
          state <= S_WAIT;
        end
        S_WAIT: begin
          wdog <= wdog + 1'b1;
          if (bus.mont_finished) begin
            bus.result <= bus.mont_result;
            bus.done <= NREQ'(1) << gidx;
            state <= S_RESP;
          end else if (TIMEOUT != 0 && wdog == WW'(TIMEOUT - 1)) begin
            bus.result <= '0;
            bus.err <= 1'b1;
            bus.done <= NREQ'(1) << gidx;
            state <= S_RESP;
          end
        end
        S_RESP: begin
          bus.done <= '0;
          bus.err <= 1'b0;
          bus.grant <= '0;
          bus.busy <= 1'b0;
          rr <= gidx == IW'(NREQ - 1) ? '0 : gidx + 1'b1;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule
